// File: rtl/packet_tx_arbiter.sv
// Round-robin packet arbiter: NUM_SRC sources each offer one complete packet,
// and the granted packet is streamed flit by flit onto a single valid/ready port.

package types;
    typedef logic [15:0] flit_t;
endpackage

module packet_tx_arbiter #(
    parameter int NUM_SRC   = 4,
    parameter int MAX_FLITS = 8,
    localparam int SRC_W    = $clog2(NUM_SRC),
    localparam int LEN_W    = $clog2(MAX_FLITS + 1)
) (
    input  logic                 nocclk,
    input  logic                 rst_n,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  types::flit_t         src_flits [NUM_SRC][MAX_FLITS],
    input  logic [LEN_W-1:0]     src_len   [NUM_SRC],
    output logic [NUM_SRC-1:0]   src_completed,
    output types::flit_t         out_flit,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 err_len
);

    localparam int FIDX_W = (MAX_FLITS > 1) ? $clog2(MAX_FLITS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]         state_q,         state_d;
    logic [SRC_W-1:0]   rr_ptr_q,        rr_ptr_d;
    logic [SRC_W-1:0]   grant_idx_q,     grant_idx_d;
    logic [LEN_W-1:0]   flit_idx_q,      flit_idx_d;
    logic               out_valid_q,     out_valid_d;
    types::flit_t       out_flit_q,      out_flit_d;
    logic [NUM_SRC-1:0] src_completed_q, src_completed_d;
    logic               busy_q,          busy_d;
    logic               err_len_q,       err_len_d;

    logic               found;
    logic [SRC_W-1:0]   pick;
    logic [SRC_W-1:0]   cand;
    logic [LEN_W-1:0]   cur_len;

    function automatic logic len_legal(input logic [LEN_W-1:0] len);
        return (len != {LEN_W{1'b0}}) && (len <= LEN_W'(MAX_FLITS));
    endfunction

    function automatic logic [SRC_W-1:0] next_src(input logic [SRC_W-1:0] idx);
        if (idx == SRC_W'(NUM_SRC - 1)) begin
            return {SRC_W{1'b0}};
        end else begin
            return idx + SRC_W'(1);
        end
    endfunction

    // Control FSM: round-robin grant, flit stepping, completion and pointer advance.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        flit_idx_d  = flit_idx_q;
        err_len_d   = 1'b0;
        found       = 1'b0;
        pick        = {SRC_W{1'b0}};
        cand        = {SRC_W{1'b0}};
        cur_len     = src_len[grant_idx_q];

        case (state_q)
            ST_IDLE: begin
                // Upward search from rr_ptr; the first hit wins.
                for (int k = 0; k < NUM_SRC; k++) begin
                    cand = SRC_W'((int'(rr_ptr_q) + k) % NUM_SRC);
                    if (!found && src_valid[cand]) begin
                        found = 1'b1;
                        pick  = cand;
                    end else begin
                        found = found;
                    end
                end
                if (found) begin
                    grant_idx_d = pick;
                    flit_idx_d  = {LEN_W{1'b0}};
                    if (len_legal(src_len[pick])) begin
                        state_d = ST_SEND;
                    end else begin
                        // Illegal length: skip straight to completion, flag it.
                        state_d   = ST_DONE;
                        err_len_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (out_ready) begin
                    if (flit_idx_q == cur_len - LEN_W'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        flit_idx_d = flit_idx_q + LEN_W'(1);
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_DONE: begin
                rr_ptr_d = next_src(grant_idx_q);
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output values are derived from the next state so every output is a flop.
    always_comb begin
        out_valid_d     = (state_d == ST_SEND);
        busy_d          = (state_d != ST_IDLE);
        out_flit_d      = '0;
        src_completed_d = {NUM_SRC{1'b0}};
        if ((state_d == ST_SEND) && (flit_idx_d < LEN_W'(MAX_FLITS))) begin
            out_flit_d = src_flits[grant_idx_d][flit_idx_d[FIDX_W-1:0]];
        end else begin
            out_flit_d = '0;
        end
        if (state_d == ST_DONE) begin
            src_completed_d[grant_idx_d] = 1'b1;
        end else begin
            src_completed_d = {NUM_SRC{1'b0}};
        end
    end

    // State and output registers; reset aborts any packet in flight.
    always_ff @(posedge nocclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            rr_ptr_q        <= {SRC_W{1'b0}};
            grant_idx_q     <= {SRC_W{1'b0}};
            flit_idx_q      <= {LEN_W{1'b0}};
            out_valid_q     <= 1'b0;
            out_flit_q      <= '0;
            src_completed_q <= {NUM_SRC{1'b0}};
            busy_q          <= 1'b0;
            err_len_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            grant_idx_q     <= grant_idx_d;
            flit_idx_q      <= flit_idx_d;
            out_valid_q     <= out_valid_d;
            out_flit_q      <= out_flit_d;
            src_completed_q <= src_completed_d;
            busy_q          <= busy_d;
            err_len_q       <= err_len_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_flit      = out_flit_q;
    assign src_completed = src_completed_q;
    assign busy          = busy_q;
    assign err_len       = err_len_q;

endmodule

// File: tb/tb_packet_tx_arbiter.sv
// Scoreboard bench for packet_tx_arbiter: stimulus pushes cycle-stamped
// expectations, a negedge monitor pops and compares what the DUT presents.

module tb_packet_tx_arbiter;

    localparam int NS = 4;
    localparam int MF = 8;
    localparam int LW = 4;

    logic               nocclk = 1'b0;
    logic               rst_n;
    logic [NS-1:0]      src_valid;
    types::flit_t       src_flits [NS][MF];
    logic [LW-1:0]      src_len   [NS];
    logic [NS-1:0]      src_completed;
    types::flit_t       out_flit;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
    logic               err_len;

    typedef struct {
        bit          is_done;
        logic [15:0] data;
        logic [3:0]  mask;
        bit          err;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   rem [NS];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   k;
    int   nk;

    packet_tx_arbiter #(.NUM_SRC(NS), .MAX_FLITS(MF)) dut (
        .nocclk        (nocclk),
        .rst_n         (rst_n),
        .src_valid     (src_valid),
        .src_flits     (src_flits),
        .src_len       (src_len),
        .src_completed (src_completed),
        .out_flit      (out_flit),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .err_len       (err_len)
    );

    always #5 nocclk = ~nocclk;

    always @(posedge nocclk) cyc <= cyc + 1;

    function automatic types::flit_t fval(input int s, input int j);
        return 16'hA000 | (16'(s) << 8) | 16'(j);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, out_valid, 32'd0);
        check({tag, "_out_flit"}, out_flit, 32'd0);
        check({tag, "_completed"}, src_completed, 32'd0);
        check({tag, "_busy"}, busy, 32'd0);
        check({tag, "_err_len"}, err_len, 32'd0);
    endtask

    // Expected flits at k+1.., extra stall cycles inserted after flit 0, then completion.
    task automatic push_pkt(input int s, input int len_eff, input int k0, input int stall,
                            input bit err, output int next_k);
        exp_t e;
        int   dc;
        for (int j = 0; j < len_eff; j++) begin
            e.is_done = 1'b0;
            e.data    = fval(s, j);
            e.mask    = 4'd0;
            e.err     = 1'b0;
            e.cyc     = k0 + 1 + j + ((j > 0) ? stall : 0);
            exp_q.push_back(e);
        end
        dc        = k0 + 1 + len_eff + stall;
        e.is_done = 1'b1;
        e.data    = 16'd0;
        e.mask    = 4'(1 << s);
        e.err     = err;
        e.cyc     = dc;
        exp_q.push_back(e);
        next_k = dc + 1;
    endtask

    // Source model: drop a request once its remaining packet count reaches zero.
    task automatic run_sources(input int budget);
        int n;
        int left;
        n = 0;
        left = 0;
        for (int i = 0; i < NS; i++) left += rem[i];
        while (left > 0 && n < budget) begin
            @(negedge nocclk);
            n++;
            for (int i = 0; i < NS; i++) begin
                if (src_completed[i] && rem[i] > 0) begin
                    rem[i]--;
                    if (rem[i] == 0) src_valid[i] = 1'b0;
                end
            end
            left = 0;
            for (int i = 0; i < NS; i++) left += rem[i];
        end
        if (left > 0) begin
            total++;
            bad++;
            $display("FAIL timeout: %0d completions still pending after %0d cycles", left, budget);
            for (int i = 0; i < NS; i++) rem[i] = 0;
            src_valid = '0;
        end
        repeat (3) @(negedge nocclk);
        check("queue_drained", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    // Monitor: compare every presented flit / completion against the queue head.
    always @(negedge nocclk) begin
        exp_t e;
        if (out_valid) begin
            check("busy_in_send", busy, 32'd1);
            if (exp_q.size() == 0 || exp_q[0].is_done) begin
                total++;
                bad++;
                $display("FAIL unexpected_flit: got %0h, expected no flit (cycle %0d)", out_flit, cyc);
            end else if (out_ready) begin
                e = exp_q.pop_front();
                check("flit_data", out_flit, e.data);
                check("flit_cycle", cyc, e.cyc);
            end else begin
                check("stall_hold", out_flit, exp_q[0].data);
            end
        end else begin
            check("idle_flit_zero", out_flit, 32'd0);
        end
        if (src_completed != '0) begin
            if (exp_q.size() == 0 || !exp_q[0].is_done) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got %0b, expected none (cycle %0d)", src_completed, cyc);
            end else begin
                e = exp_q.pop_front();
                check("done_mask", src_completed, e.mask);
                check("done_err", err_len, e.err);
                check("done_cycle", cyc, e.cyc);
                check("busy_in_done", busy, 32'd1);
            end
        end else begin
            check("err_without_done", err_len, 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        src_valid = '0;
        out_ready = 1'b1;
        for (int s = 0; s < NS; s++) begin
            src_len[s] = 4'd0;
            rem[s]     = 0;
            for (int j = 0; j < MF; j++) src_flits[s][j] = fval(s, j);
        end
        repeat (3) @(posedge nocclk);
        #1;
        check_reset_state("rst");
        rst_n = 1'b1;

        // Single packet, len 3
        @(posedge nocclk); #1;
        src_len[0] = 4'd3;
        src_valid  = 4'b0001;
        k = cyc;
        push_pkt(0, 3, k, 0, 1'b0, nk);
        rem[0] = 1;
        run_sources(40);

        // All four request from reset: order 0,1,2,3,0
        @(posedge nocclk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge nocclk);
        #1;
        check_reset_state("rst2");
        rst_n = 1'b1;
        for (int s = 0; s < NS; s++) src_len[s] = 4'd2;
        src_valid = 4'b1111;
        k = cyc;
        push_pkt(0, 2, k, 0, 1'b0, nk);
        push_pkt(1, 2, nk, 0, 1'b0, nk);
        push_pkt(2, 2, nk, 0, 1'b0, nk);
        push_pkt(3, 2, nk, 0, 1'b0, nk);
        push_pkt(0, 2, nk, 0, 1'b0, nk);
        rem[0] = 2; rem[1] = 1; rem[2] = 1; rem[3] = 1;
        run_sources(100);

        // Illegal length 0 on source 1 (rr_ptr 1 -> 2)
        @(posedge nocclk); #1;
        src_len[1] = 4'd0;
        src_valid  = 4'b0010;
        k = cyc;
        push_pkt(1, 0, k, 0, 1'b1, nk);
        rem[1] = 1;
        run_sources(20);

        // Source 2 len MAX+1 with source 1 legal: rr_ptr 2 grants 2 first
        @(posedge nocclk); #1;
        src_len[1] = 4'd1;
        src_len[2] = 4'd9;
        src_valid  = 4'b0110;
        k = cyc;
        push_pkt(2, 0, k, 0, 1'b1, nk);
        push_pkt(1, 1, nk, 0, 1'b0, nk);
        rem[1] = 1; rem[2] = 1;
        run_sources(40);

        // Backpressure: len 4, ready low on SEND cycles 2-4 (rr_ptr 2 -> 3)
        @(posedge nocclk); #1;
        src_len[2] = 4'd4;
        src_valid  = 4'b0100;
        k = cyc;
        push_pkt(2, 4, k, 3, 1'b0, nk);
        rem[2] = 1;
        @(posedge nocclk); #1;
        @(posedge nocclk); #1;
        out_ready = 1'b0;
        @(posedge nocclk); #1;
        @(posedge nocclk); #1;
        @(posedge nocclk); #1;
        out_ready = 1'b1;
        run_sources(40);

        // Wrap-around: rr_ptr 3, requests 1001 -> source 3 then 0
        @(posedge nocclk); #1;
        src_len[3] = 4'd2;
        src_len[0] = 4'd1;
        src_valid  = 4'b1001;
        k = cyc;
        push_pkt(3, 2, k, 0, 1'b0, nk);
        push_pkt(0, 1, nk, 0, 1'b0, nk);
        rem[0] = 1; rem[3] = 1;
        run_sources(40);

        // Reset during flit 2 of 5, then full resend from flit 0
        @(posedge nocclk); #1;
        src_len[0] = 4'd5;
        src_valid  = 4'b0001;
        k = cyc;
        push_pkt(0, 5, k, 0, 1'b0, nk);
        @(posedge nocclk); #1;
        @(posedge nocclk); #1;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("rst_mid");
        exp_q.delete();
        repeat (2) @(posedge nocclk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        k = cyc;
        push_pkt(0, 5, k, 0, 1'b0, nk);
        rem[0] = 1;
        run_sources(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/packet_tx_arbiter.md
PACKET_TX_ARBITER -- requirements
Module: packet_tx_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4: number of packet sources sharing the output flit port; legal range 2..8.
REQ-002 Parameter MAX_FLITS, default 8: maximum flits per packet.
REQ-003 Localparams: SRC_W = $clog2(NUM_SRC); LEN_W = $clog2(MAX_FLITS+1).
REQ-004 nocclk  input  1  clock; all state updates on posedge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 src_valid  input  NUM_SRC  source i holds one complete packet.
REQ-007 src_flits  input  NUM_SRC x MAX_FLITS x types::flit_t  packet flits; index 0 is the head flit.
REQ-008 src_len  input  NUM_SRC x LEN_W  number of valid flits in the packet.
REQ-009 src_completed  output  NUM_SRC  one-cycle pulse telling source i its packet is fully sent (pop).
REQ-010 out_flit  output  types::flit_t  flit presented downstream.
REQ-011 out_valid  output  1  out_flit is valid.
REQ-012 out_ready  input  1  downstream accepts out_flit this cycle.
REQ-013 busy  output  1  FSM is not in IDLE.
REQ-014 err_len  output  1  one-cycle pulse when a granted packet has an illegal length.

Function
REQ-015 The FSM SHALL have three states: IDLE, SEND and DONE.
REQ-016 IDLE SHALL grant a requester only if some src_valid bit is 1.
- The grant SHALL be round-robin, searching upward from rr_ptr with wrap-around.
- The FSM SHALL latch grant_idx, clear flit_idx to 0, and go to SEND on the next edge.
REQ-017 Latency SHALL be exactly one cycle: src_valid seen in IDLE at cycle N gives out_valid=1 at cycle N+1.
REQ-018 In SEND:
- out_valid SHALL be 1.
- out_flit SHALL equal src_flits[grant_idx][flit_idx].
- out_valid and out_flit SHALL be held stable until out_ready=1.
REQ-019 In SEND, out_valid&out_ready SHALL increment flit_idx.
- If flit_idx == src_len[grant_idx]-1, the FSM SHALL go to DONE instead.
REQ-020 In DONE:
- src_completed[grant_idx] SHALL be 1 for exactly one cycle.
- rr_ptr SHALL become (grant_idx+1) mod NUM_SRC.
- The FSM SHALL return to IDLE.
REQ-021 Back-to-back packets SHALL have a gap of exactly two cycles with out_valid=0 (DONE and IDLE).
REQ-022 While not in SEND, out_valid SHALL be 0 and out_flit SHALL be '0.
REQ-023 src_completed SHALL be 0 in all states except DONE.
REQ-024 A source SHALL hold its inputs stable from grant until its src_completed pulse.
- If src_valid[grant_idx] drops during SEND, the block SHALL ignore it and finish the packet.
REQ-025 A granted src_len of 0 or greater than MAX_FLITS SHALL send no flits.
- The FSM SHALL go IDLE -> DONE directly, pulse err_len with src_completed, and advance rr_ptr.
REQ-026 Requests that arrive while busy SHALL wait; the block SHALL never drop or reorder a request.
REQ-027 Fairness: a requester held continuously valid SHALL be granted within NUM_SRC packet slots.
REQ-028 When all sources request, grant order SHALL be rr_ptr, rr_ptr+1, ..., wrapping from NUM_SRC-1 to 0.
REQ-029 All index arithmetic SHALL be unsigned.
- flit_idx SHALL be LEN_W bits wide.
- rr_ptr and grant_idx SHALL be SRC_W bits wide.

Reset
REQ-030 While rst_n=0, the following SHALL hold, independent of nocclk:
- FSM = IDLE; rr_ptr = 0; grant_idx = 0; flit_idx = 0.
- out_valid = 0; out_flit = '0; src_completed = '0; busy = 0; err_len = 0.
REQ-031 A reset in the middle of a packet SHALL abort that packet with no src_completed pulse.
- The source keeps its packet; after reset it is rearbitrated starting from rr_ptr = 0.

Verification
REQ-032 Single packet with out_ready always 1:
- Stimulus: src_valid=4'b0001, src_len[0]=3.
- Response: flits 0,1,2 on three consecutive cycles starting one cycle after the request; then src_completed=4'b0001 for one cycle.
REQ-033 All four sources requesting, each with len 2, from reset:
- Response: grant order 0,1,2,3,0; each packet gives 2 flits then a completed pulse; two idle cycles between packets.
REQ-034 Backpressure:
- Stimulus: len 4, with out_ready low on cycles 2-4 of SEND.
- Response: out_flit stable while stalled; no flit duplicated or skipped; completed pulse only after the 4th acceptance.
REQ-035 Illegal length:
- Stimulus: src_len[1]=0, then later src_len[2]=MAX_FLITS+1.
- Response: out_valid stays 0; err_len and src_completed[1] (then [2]) pulse together; rr_ptr advances.
REQ-036 Reset during SEND:
- Stimulus: rst_n low in the middle of flit 2 of 5.
- Response: all outputs are 0 immediately; after release the same packet is resent from flit 0.
REQ-037 Wrap-around:
- Stimulus: rr_ptr=3, src_valid=4'b1001.
- Response: source 3 is granted first, then source 0.
